dmem_dual_lane_responder: RTL and testbench

//  Memory-side responder for the two load/store lanes driven by the dual-issue core's M stage.

---
 rtl/dmem_pkg.sv | 36 +++
 rtl/dmem_bank.sv | 36 +++
 rtl/dmem_dual_lane_responder.sv | 217 +++++++++++++++++++++
 tb/tb_dmem_dual_lane_responder.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared types, default sizes and address-decode helpers for
//                the dual-lane data-memory responder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

    localparam int DW_DEF    = 16;
    localparam int AW_DEF    = 16;
    localparam int DEPTH_DEF = 256;

    typedef enum logic [1:0] {
        CLEAR  = 2'd0,
        IDLE   = 2'd1,
        REPLAY = 2'd2
    } state_t;

    // Byte address to word index; high bits drop so addresses wrap modulo depth.
    function automatic logic [31:0] word_idx(input logic [31:0] addr, input int depth);
        return (addr >> 1) & 32'(depth - 1);
    endfunction

    function automatic logic bank_of(input logic [31:0] idx);
        return idx[0];
    endfunction

    function automatic logic [31:0] row_of(input logic [31:0] idx);
        return idx >> 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_bank.sv
// ============================================================================
//  Module      : dmem_bank
//  Description : Single-port synchronous RAM, one read or write per cycle,
//                registered read data.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_bank #(
    parameter int DW   = 16,
    parameter int ROWS = 128,
    parameter int RW   = $clog2(ROWS)
) (
    input  logic          clock,
    input  logic          en,
    input  logic          we,
    input  logic [RW-1:0] row,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] r_mem [ROWS];

    always_ff @(posedge clock) begin
        if (en) begin
            if (we) begin
                r_mem[row] <= wdata;
            end else begin
                rdata <= r_mem[row];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/dmem_dual_lane_responder.sv
// ============================================================================
//  Module      : dmem_dual_lane_responder
//  Description : Two-lane load/store responder over two word-interleaved banks
//                with same-bank serialisation and a post-reset clear sequence.
//                Optional macro DMEM_SAME_ADDR_BYPASS_EN removes the stall for
//                same-word store->load and load/load bundles.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_dual_lane_responder
    import dmem_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int AW    = AW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          req_v0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    input  logic          req_v1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic [DW-1:0] rdata0,
    output logic          rvalid0,
    output logic [DW-1:0] rdata1,
    output logic          rvalid1,
    output logic          stall,
    output logic          busy
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int ROW_W = IDX_W - 1;
    localparam int ROWS  = DEPTH / 2;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    state_t             r_state, w_next;
    logic [ROW_W-1:0]   r_clr;
    logic               r_rvalid0, r_rvalid1;
    logic               r_src0, r_src1, r_byp_sel;
    logic [DW-1:0]      r_byp_data, r_hold0, r_hold1;
    logic               r_we1, r_bank1;
    logic [ROW_W-1:0]   r_row1;
    logic [DW-1:0]      r_wd1;

    logic [IDX_W-1:0]   w_idx0, w_idx1;
    logic               w_bank0, w_bank1;
    logic [ROW_W-1:0]   w_row0, w_row1;
    logic               w_conflict, w_bypass;
    logic [1:0]         w_en, w_we;
    logic [ROW_W-1:0]   w_row [2];
    logic [DW-1:0]      w_wd [2];
    logic [DW-1:0]      w_rd [2];
    logic               w_set_rv0, w_set_rv1, w_src0, w_src1, w_byp_sel;
    logic               w_byp_load, w_latch1;

    assign w_idx0  = IDX_W'(word_idx(32'(addr0), DEPTH));
    assign w_idx1  = IDX_W'(word_idx(32'(addr1), DEPTH));
    assign w_bank0 = bank_of(32'(w_idx0));
    assign w_bank1 = bank_of(32'(w_idx1));
    assign w_row0  = ROW_W'(row_of(32'(w_idx0)));
    assign w_row1  = ROW_W'(row_of(32'(w_idx1)));

    assign w_conflict = req_v0 & req_v1 & (w_bank0 == w_bank1);

`ifdef DMEM_SAME_ADDR_BYPASS_EN
    assign w_bypass = w_conflict & (w_idx0 == w_idx1) & ~we1;
`else
    assign w_bypass = 1'b0;
`endif

    always_comb begin
        w_next     = r_state;
        stall      = 1'b0;
        busy       = 1'b0;
        w_en       = '0;
        w_we       = '0;
        w_row[0]   = '0;
        w_row[1]   = '0;
        w_wd[0]    = '0;
        w_wd[1]    = '0;
        w_set_rv0  = 1'b0;
        w_set_rv1  = 1'b0;
        w_src0     = r_src0;
        w_src1     = r_src1;
        w_byp_sel  = r_byp_sel;
        w_byp_load = 1'b0;
        w_latch1   = 1'b0;
        case (r_state)
            CLEAR: begin
                busy     = 1'b1;
                stall    = 1'b1;
                w_en     = 2'b11;
                w_we     = 2'b11;
                w_row[0] = r_clr;
                w_row[1] = r_clr;
                if (r_clr == LAST_ROW) begin
                    w_next = IDLE;
                end
            end
            IDLE: begin
                if (req_v0) begin
                    w_en[w_bank0]  = 1'b1;
                    w_we[w_bank0]  = we0;
                    w_row[w_bank0] = w_row0;
                    w_wd[w_bank0]  = wdata0;
                    if (!we0) begin
                        w_set_rv0 = 1'b1;
                        w_src0    = w_bank0;
                    end
                end
                if (req_v1) begin
                    if (w_bypass) begin
                        // Lane 1 rides on lane 0's access: forwarded store data or shared read.
                        w_set_rv1  = 1'b1;
                        w_src1     = w_bank0;
                        w_byp_sel  = we0;
                        w_byp_load = we0;
                    end else if (w_conflict) begin
                        stall    = 1'b1;
                        w_latch1 = 1'b1;
                        w_next   = REPLAY;
                    end else begin
                        w_en[w_bank1]  = 1'b1;
                        w_we[w_bank1]  = we1;
                        w_row[w_bank1] = w_row1;
                        w_wd[w_bank1]  = wdata1;
                        if (!we1) begin
                            w_set_rv1 = 1'b1;
                            w_src1    = w_bank1;
                            w_byp_sel = 1'b0;
                        end
                    end
                end
            end
            REPLAY: begin
                w_en[r_bank1]  = 1'b1;
                w_we[r_bank1]  = r_we1;
                w_row[r_bank1] = r_row1;
                w_wd[r_bank1]  = r_wd1;
                if (!r_we1) begin
                    w_set_rv1 = 1'b1;
                    w_src1    = r_bank1;
                    w_byp_sel = 1'b0;
                end
                w_next = IDLE;
            end
            default: w_next = CLEAR;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= CLEAR;
            r_clr      <= '0;
            r_rvalid0  <= 1'b0;
            r_rvalid1  <= 1'b0;
            r_src0     <= 1'b0;
            r_src1     <= 1'b0;
            r_byp_sel  <= 1'b0;
            r_byp_data <= '0;
            r_hold0    <= '0;
            r_hold1    <= '0;
            r_we1      <= 1'b0;
            r_bank1    <= 1'b0;
            r_row1     <= '0;
            r_wd1      <= '0;
        end else begin
            r_state    <= w_next;
            r_clr      <= (r_state == CLEAR) ? r_clr + 1'b1 : '0;
            r_rvalid0  <= w_set_rv0;
            r_rvalid1  <= w_set_rv1;
            r_src0     <= w_src0;
            r_src1     <= w_src1;
            r_byp_sel  <= w_byp_sel;
            r_hold0    <= rdata0;
            r_hold1    <= rdata1;
            if (w_byp_load) begin
                r_byp_data <= wdata0;
            end
            if (w_latch1) begin
                r_we1   <= we1;
                r_bank1 <= w_bank1;
                r_row1  <= w_row1;
                r_wd1   <= wdata1;
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        dmem_bank #(
            .DW   (DW),
            .ROWS (ROWS),
            .RW   (ROW_W)
        ) u_bank (
            .clock (clock),
            .en    (w_en[b]),
            .we    (w_we[b]),
            .row   (w_row[b]),
            .wdata (w_wd[b]),
            .rdata (w_rd[b])
        );
    end

    // Bank outputs are only trusted in the response cycle; otherwise replay the last value.
    assign rvalid0 = r_rvalid0;
    assign rvalid1 = r_rvalid1;
    assign rdata0  = r_rvalid0 ? w_rd[r_src0] : r_hold0;
    assign rdata1  = !r_rvalid1 ? r_hold1 : (r_byp_sel ? r_byp_data : w_rd[r_src1]);

endmodule

`default_nettype wire

// File: tb/tb_dmem_dual_lane_responder.sv
// ============================================================================
//  Module      : tb_dmem_dual_lane_responder
//  Description : Self-checking bench: directed scenarios plus random bundles
//                compared against a word-array memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_dual_lane_responder;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_v0 = 1'b0, we0 = 1'b0, req_v1 = 1'b0, we1 = 1'b0;
    logic [15:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
    logic [15:0] rdata0, rdata1;
    logic        rvalid0, rvalid1, stall, busy;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] mem [256];
    logic [15:0] last0 = '0, last1 = '0;

    always #5 clock = ~clock;

    dmem_dual_lane_responder dut (
        .clock   (clock),
        .reset   (reset),
        .req_v0  (req_v0),
        .we0     (we0),
        .addr0   (addr0),
        .wdata0  (wdata0),
        .req_v1  (req_v1),
        .we1     (we1),
        .addr1   (addr1),
        .wdata1  (wdata1),
        .rdata0  (rdata0),
        .rvalid0 (rvalid0),
        .rdata1  (rdata1),
        .rvalid1 (rvalid1),
        .stall   (stall),
        .busy    (busy)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v0_, input logic w0_, input logic [15:0] a0_, input logic [15:0] d0_,
                         input logic v1_, input logic w1_, input logic [15:0] a1_, input logic [15:0] d1_);
        req_v0 = v0_; we0 = w0_; addr0 = a0_; wdata0 = d0_;
        req_v1 = v1_; we1 = w1_; addr1 = a1_; wdata1 = d1_;
    endtask

    task automatic check_out(input string tag, input logic rv0, input logic [15:0] e0,
                             input logic rv1, input logic [15:0] e1);
        chk({tag, ".rvalid0"}, 16'(rvalid0), 16'(rv0));
        if (rv0) last0 = e0;
        chk({tag, ".rdata0"}, rdata0, last0);
        chk({tag, ".rvalid1"}, 16'(rvalid1), 16'(rv1));
        if (rv1) last1 = e1;
        chk({tag, ".rdata1"}, rdata1, last1);
    endtask

    // One bundle, expectations derived from the memory model and the bank/ordering rules.
    task automatic bundle(input string tag,
                          input logic v0_, input logic w0_, input logic [15:0] a0_, input logic [15:0] d0_,
                          input logic v1_, input logic w1_, input logic [15:0] a1_, input logic [15:0] d1_);
        int          i0, i1;
        logic        cf, byp, es, ld0, ld1;
        logic [15:0] e0, e1;
        i0  = int'(a0_ >> 1) % 256;
        i1  = int'(a1_ >> 1) % 256;
        cf  = v0_ && v1_ && ((i0 % 2) == (i1 % 2));
        byp = 1'b0;
`ifdef DMEM_SAME_ADDR_BYPASS_EN
        byp = cf && (i0 == i1) && !w1_;
`endif
        es  = cf && !byp;
        ld0 = v0_ && !w0_;
        ld1 = v1_ && !w1_;
        e0  = '0;
        e1  = '0;
        if (v0_) begin
            if (w0_) mem[i0] = d0_;
            else     e0 = mem[i0];
        end
        if (v1_) begin
            if (w1_) mem[i1] = d1_;
            else     e1 = mem[i1];
        end
        drive(v0_, w0_, a0_, d0_, v1_, w1_, a1_, d1_);
        #1;
        chk({tag, ".stall"}, 16'(stall), 16'(es));
        @(posedge clock); #1;
        if (!es) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0);
            check_out(tag, ld0, e0, ld1, e1);
        end else begin
            chk({tag, ".stall_n1"}, 16'(stall), 16'd0);
            check_out({tag, "@n1"}, ld0, e0, 1'b0, 16'd0);
            @(posedge clock); #1;
            drive(0, 0, 0, 0, 0, 0, 0, 0);
            check_out({tag, "@n2"}, 1'b0, 16'd0, ld1, e1);
        end
    endtask

    task automatic wait_clear(input string tag);
        int   cnt;
        logic saw_rv1;
        cnt     = 0;
        saw_rv1 = 1'b0;
        while (busy && cnt < 1000) begin
            if (rvalid1) saw_rv1 = 1'b1;
            cnt++;
            @(posedge clock); #1;
        end
        chk({tag, ".busy_cycles"}, 16'(cnt), 16'd128);
        chk({tag, ".no_rvalid1"}, 16'(saw_rv1), 16'd0);
        for (int k = 0; k < 256; k++) mem[k] = '0;
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clock);
        #1;
        chk("rst.busy", 16'(busy), 16'd1);
        chk("rst.stall", 16'(stall), 16'd1);
        chk("rst.rvalid0", 16'(rvalid0), 16'd0);
        chk("rst.rvalid1", 16'(rvalid1), 16'd0);
        chk("rst.rdata0", rdata0, 16'h0000);
        chk("rst.rdata1", rdata1, 16'h0000);
        reset = 1'b1;

        // T1 clear sequence
        drive(1, 1, 16'h0010, 16'hDEAD, 1, 1, 16'h0012, 16'hBEEF);
        wait_clear("t1");
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        bundle("t1.ld", 1, 0, 16'h00FE, 0, 0, 0, 0, 0);
        bundle("t1.ignored", 1, 0, 16'h0010, 0, 1, 0, 16'h0012, 0);

        // T2 parallel
        bundle("t2.st", 1, 1, 16'h0000, 16'hAAAA, 1, 1, 16'h0002, 16'h5555);
        bundle("t2.ld", 1, 0, 16'h0000, 0, 1, 0, 16'h0002, 0);

        // T3 conflict
        bundle("t3.st", 1, 1, 16'h0004, 16'h1111, 1, 1, 16'h000A, 16'h2222);
        bundle("t3.st2", 1, 1, 16'h0008, 16'h3333, 0, 0, 0, 0);
        bundle("t3.ld", 1, 0, 16'h0004, 0, 1, 0, 16'h0008, 0);

        // T4 same-address ordering
        bundle("t4.st_ld", 1, 1, 16'h0010, 16'h1234, 1, 0, 16'h0010, 0);
        bundle("t4.st_st", 1, 1, 16'h0014, 16'h0A0A, 1, 1, 16'h0014, 16'h0B0B);
        bundle("t4.ld_ld", 1, 0, 16'h0014, 0, 1, 0, 16'h0015, 0);

        // T5 wrap and low-bit alias
        bundle("t5.st", 1, 1, 16'h0200, 16'hBEEF, 0, 0, 0, 0);
        bundle("t5.ld", 0, 0, 0, 0, 1, 0, 16'h0000, 0);
        bundle("t5.alias", 1, 1, 16'h0003, 16'hC0DE, 1, 0, 16'h0002, 0);

        // Random bundles over a small, wrapping address window
        for (int n = 0; n < 300; n++) begin
            bundle("rnd",
                   $urandom_range(0, 3) != 0, 1'($urandom), 16'($urandom) & 16'h020F, 16'($urandom),
                   $urandom_range(0, 3) != 0, 1'($urandom), 16'($urandom) & 16'h020F, 16'($urandom));
        end

        // T6 reset during REPLAY
        drive(1, 0, 16'h0020, 0, 1, 1, 16'h0024, 16'h7777);
        #1;
        chk("t6.stall", 16'(stall), 16'd1);
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        chk("t6.busy", 16'(busy), 16'd1);
        chk("t6.rvalid1", 16'(rvalid1), 16'd0);
        chk("t6.rdata0", rdata0, 16'h0000);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        last0 = '0;
        last1 = '0;
        wait_clear("t6");
        for (int k = 0; k < 128; k++) begin
            bundle("t6.rd", 1, 0, 16'(4 * k), 0, 1, 0, 16'(4 * k + 2), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
